// File: rtl/multichannel_delay_line.sv
// Per-channel programmable integer sample delay for delay-and-sum beamforming.
// Optional macro DELAY_RAMP_EN: cfg writes set a target that the active delay walks toward one step per frame.
module multichannel_delay_line #(
    parameter int DATA_W   = 19,
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 64,
    parameter int DELAY_W  = $clog2(DEPTH),
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         cfg_wr_en,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [DELAY_W-1:0]           cfg_delay,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         fill_done
);

    localparam logic [DELAY_W-1:0] FILL_MAX = DELAY_W'(DEPTH - 1);

    logic [DATA_W-1:0]           mem [CHANNELS][DEPTH];
    logic [DELAY_W-1:0]          rd_idx [CHANNELS];

    logic [DELAY_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [DELAY_W-1:0]          fill_q, fill_d;
    logic                        fill_done_q, fill_done_d;
    logic                        out_valid_q, out_valid_d;
    logic [CHANNELS*DATA_W-1:0]  out_data_q, out_data_d;
    logic [DELAY_W-1:0]          delay_q [CHANNELS];
    logic [DELAY_W-1:0]          delay_d [CHANNELS];
`ifdef DELAY_RAMP_EN
    logic [DELAY_W-1:0]          target_q [CHANNELS];
    logic [DELAY_W-1:0]          target_d [CHANNELS];
`endif

    // Sample storage is never reset; the fill count hides stale contents.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                mem[c][wr_ptr_q] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            rd_idx[c] = wr_ptr_q - delay_q[c];
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        out_valid_d = in_valid;
        out_data_d  = out_data_q;
        delay_d     = delay_q;
`ifdef DELAY_RAMP_EN
        target_d    = target_q;
`endif
        if (in_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (delay_q[c] == '0) begin
                    out_data_d[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
                end else if (delay_q[c] > fill_q) begin
                    out_data_d[c*DATA_W +: DATA_W] = '0;
                end else begin
                    out_data_d[c*DATA_W +: DATA_W] = mem[c][rd_idx[c]];
                end
            end
`ifdef DELAY_RAMP_EN
            // Step after this frame's output so each transition repeats or skips at most one sample.
            for (int c = 0; c < CHANNELS; c++) begin
                if (delay_q[c] < target_q[c]) begin
                    delay_d[c] = delay_q[c] + 1'b1;
                end else if (delay_q[c] > target_q[c]) begin
                    delay_d[c] = delay_q[c] - 1'b1;
                end
            end
`endif
        end
        fill_done_d = (fill_d == FILL_MAX);

        // Out-of-range channel indices match no entry and are dropped.
        if (cfg_wr_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_ch == CH_W'(c)) begin
`ifdef DELAY_RAMP_EN
                    target_d[c] = cfg_delay;
`else
                    delay_d[c] = cfg_delay;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            fill_done_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                delay_q[c] <= '0;
`ifdef DELAY_RAMP_EN
                target_q[c] <= '0;
`endif
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            fill_done_q <= fill_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int c = 0; c < CHANNELS; c++) begin
                delay_q[c] <= delay_d[c];
`ifdef DELAY_RAMP_EN
                target_q[c] <= target_d[c];
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign fill_done = fill_done_q;

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Scoreboard bench for multichannel_delay_line: stimulus pushes expected frames, a negedge monitor pops and compares.
module tb_multichannel_delay_line;

    localparam int DATA_W   = 19;
    localparam int CHANNELS = 8;
    localparam int DEPTH    = 64;
    localparam int DELAY_W  = $clog2(DEPTH);
    localparam int CH_W     = $clog2(CHANNELS);
    localparam int CW       = CHANNELS * DATA_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic [CW-1:0]       in_data = '0;
    logic                cfg_wr_en = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [DELAY_W-1:0]  cfg_delay = '0;
    logic                out_valid;
    logic [CW-1:0]       out_data;
    logic                fill_done;

    multichannel_delay_line #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .cfg_wr_en(cfg_wr_en), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
        .out_valid(out_valid), .out_data(out_data), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] data;
        logic          fill_done;
        int            frame;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] hist[$];
    int            n_written;
    int            mdelay [CHANNELS];
    int            mtarget [CHANNELS];
    int            checks = 0;
    int            fails = 0;

    task automatic check_val(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] make_frame(input int k);
        logic [CW-1:0] f;
        for (int c = 0; c < CHANNELS; c++) begin
            f[c*DATA_W +: DATA_W] = DATA_W'(100 * k + c);
        end
        return f;
    endfunction

    function automatic void model_reset();
        hist.delete();
        n_written = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            mdelay[c]  = 0;
            mtarget[c] = 0;
        end
    endfunction

    function automatic void model_cfg(input int ch, input int dly);
        if (ch < CHANNELS) begin
`ifdef DELAY_RAMP_EN
            mtarget[ch] = dly;
`else
            mdelay[ch] = dly;
`endif
        end
    endfunction

    // Drive one frame (optionally with a simultaneous cfg write) and queue its expected output.
    task automatic send_frame(input int k, input bit wr = 1'b0, input int ch = 0, input int dly = 0);
        exp_t          e;
        logic [CW-1:0] f;
        logic [CW-1:0] old;
        @(negedge clk);
        f         = make_frame(k);
        in_valid  = 1'b1;
        in_data   = f;
        cfg_wr_en = wr;
        cfg_ch    = CH_W'(ch);
        cfg_delay = DELAY_W'(dly);
        for (int c = 0; c < CHANNELS; c++) begin
            if (mdelay[c] == 0) begin
                e.data[c*DATA_W +: DATA_W] = f[c*DATA_W +: DATA_W];
            end else if (mdelay[c] > n_written) begin
                e.data[c*DATA_W +: DATA_W] = '0;
            end else begin
                old = hist[n_written - mdelay[c]];
                e.data[c*DATA_W +: DATA_W] = old[c*DATA_W +: DATA_W];
            end
        end
        hist.push_back(f);
        n_written++;
        e.fill_done = (n_written >= DEPTH - 1);
        e.frame     = k;
        sb.push_back(e);
`ifdef DELAY_RAMP_EN
        for (int c = 0; c < CHANNELS; c++) begin
            if (mdelay[c] < mtarget[c]) mdelay[c]++;
            else if (mdelay[c] > mtarget[c]) mdelay[c]--;
        end
`endif
        if (wr) model_cfg(ch, dly);
    endtask

    task automatic cfg_write(input int ch, input int dly);
        @(negedge clk);
        in_valid  = 1'b0;
        cfg_wr_en = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_delay = DELAY_W'(dly);
        model_cfg(ch, dly);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            in_valid  = 1'b0;
            cfg_wr_en = 1'b0;
        end
    endtask

    // Asserts reset between edges and checks the outputs clear without waiting for a clock.
    task automatic do_reset();
        idle(2);
        #2 rst = 1'b0;
        #1;
        check_val("reset out_valid", 0, 32'(out_valid), 32'd0);
        check_val("reset out_data_nonzero", 0, 32'(out_data != '0), 32'd0);
        check_val("reset fill_done", 0, 32'(fill_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected out_valid: got 1, expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int c = 0; c < CHANNELS; c++) begin
                    check_val($sformatf("frame%0d ch", e.frame), c,
                              32'(out_data[c*DATA_W +: DATA_W]), 32'(e.data[c*DATA_W +: DATA_W]));
                end
                check_val("fill_done frame", e.frame, 32'(fill_done), 32'(e.fill_done));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // All delays zero: outputs track the same frame
        for (int k = 1; k <= 10; k++) send_frame(k);

        // Channel 2 delayed by 5
        do_reset();
        cfg_write(2, 5);
        for (int k = 1; k <= 20; k++) send_frame(k);

        // Maximum delay across several pointer wraps
        do_reset();
        cfg_write(0, DEPTH - 1);
        for (int k = 1; k <= 200; k++) send_frame(k);

        // Config write coinciding with a frame uses the old delay for that frame
        do_reset();
        for (int k = 1; k <= 5; k++) send_frame(k);
        send_frame(6, 1'b1, 1, 3);
        for (int k = 7; k <= 12; k++) send_frame(k);

        // Reset in the middle of a delayed stream
        do_reset();
        cfg_write(3, 10);
        for (int k = 1; k <= 100; k++) send_frame(k);
        do_reset();
        cfg_write(3, 10);
        for (int k = 1; k <= 20; k++) send_frame(k);

        // Delay change on channel 4 (ramped when the option is built in)
        do_reset();
        cfg_write(4, 4);
        for (int k = 1; k <= 12; k++) send_frame(k);

        idle(4);
        check_val("scoreboard drained", 0, 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
